// File: rtl/sort_pkg.sv
// Shared types and constants for the in-place selection-sort engine.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    SWAP,
    DONE
  } sort_state_t;

  localparam logic ASCENDING  = 1'b0;
  localparam logic DESCENDING = 1'b1;

endpackage

// File: rtl/sort_if.sv
// Control/load/read bundle for sort_engine; swap_count exists only when
// SORT_SWAP_COUNT_EN is defined.
interface sort_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             s;
  logic             desc;
  logic             init_mode;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] init_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
`ifdef SORT_SWAP_COUNT_EN
  logic [AW-1:0]    swap_count;

  modport master (
    output s, desc, init_mode, init_addr, init_data, rd_addr,
    input  rd_data, busy, done, swap_count
  );
  modport slave (
    input  s, desc, init_mode, init_addr, init_data, rd_addr,
    output rd_data, busy, done, swap_count
  );
`else
  modport master (
    output s, desc, init_mode, init_addr, init_data, rd_addr,
    input  rd_data, busy, done
  );
  modport slave (
    input  s, desc, init_mode, init_addr, init_data, rd_addr,
    output rd_data, busy, done
  );
`endif
endinterface

// File: rtl/sort_regfile.sv
// DEPTH x WIDTH register array: external read, two index reads, external
// write and a dual-write swap port; asynchronously cleared.
module sort_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic [AW-1:0]    i_addr,
  output logic [WIDTH-1:0] i_data,
  input  logic [AW-1:0]    j_addr,
  output logic [WIDTH-1:0] j_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             swap_en,
  input  logic [AW-1:0]    swap_i,
  input  logic [WIDTH-1:0] swap_i_data,
  input  logic [AW-1:0]    swap_k,
  input  logic [WIDTH-1:0] swap_k_data
);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: this array is reset on purpose; a sort aborted by reset must leave every entry at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
    end else if (swap_en) begin
      mem[swap_k] <= swap_k_data;
      mem[swap_i] <= swap_i_data;
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH_V)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Out-of-range addresses (non power-of-two DEPTH) read as zero.
  assign rd_data = ({1'b0, rd_addr} < DEPTH_V) ? mem[rd_addr] : '0;
  assign i_data  = ({1'b0, i_addr}  < DEPTH_V) ? mem[i_addr]  : '0;
  assign j_data  = ({1'b0, j_addr}  < DEPTH_V) ? mem[j_addr]  : '0;

endmodule

// File: rtl/sort_engine.sv
// In-place selection sort over a DEPTH x WIDTH array, fixed latency.
// Optional SORT_SWAP_COUNT_EN adds a count of performed swaps.
module sort_engine
  import sort_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  sort_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PASS_END = AW'(DEPTH - 2);

  sort_state_t      state;
  logic [AW-1:0]    i, j, k;
  logic [WIDTH-1:0] best;
  logic             order;
  logic             busy, done;
  logic [WIDTH-1:0] i_data, j_data;
  logic             idle_like, swap_en;
`ifdef SORT_SWAP_COUNT_EN
  logic [AW-1:0]    swap_count;
  assign bus.swap_count = swap_count;
`endif

  function automatic logic better(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic ord);
    return (ord == DESCENDING) ? (a > b) : (a < b);
  endfunction

  assign idle_like = (state == IDLE) || (state == DONE);
  assign swap_en   = (state == SWAP) && (k != i);

  sort_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (bus.rd_addr),
    .rd_data     (bus.rd_data),
    .i_addr      (i),
    .i_data      (i_data),
    .j_addr      (j),
    .j_data      (j_data),
    .wr_en       (idle_like && bus.init_mode),
    .wr_addr     (bus.init_addr),
    .wr_data     (bus.init_data),
    .swap_en     (swap_en),
    .swap_i      (i),
    .swap_i_data (best),
    .swap_k      (k),
    .swap_k_data (i_data)
  );

  // NOTE: all FSM state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      best  <= '0;
      order <= ASCENDING;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SORT_SWAP_COUNT_EN
      swap_count <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // A load in the same cycle as s takes priority and cancels the start.
          if (bus.init_mode) begin
            done  <= 1'b0;
            state <= IDLE;
          end else if (bus.s) begin
            order <= bus.desc;
            done  <= 1'b0;
            busy  <= 1'b1;
            i     <= '0;
            state <= LOAD;
`ifdef SORT_SWAP_COUNT_EN
            swap_count <= '0;
`endif
          end
        end
        LOAD: begin
          best  <= i_data;
          k     <= i;
          j     <= i + 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          if (better(j_data, best, order)) begin
            best <= j_data;
            k    <= j;
          end
          if (j == LAST_IDX) state <= SWAP;
          else               j     <= j + 1'b1;
        end
        SWAP: begin
`ifdef SORT_SWAP_COUNT_EN
          if (k != i) swap_count <= swap_count + 1'b1;
`endif
          if (i == PASS_END) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i     <= i + 1'b1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_sort_engine.sv
// Directed self-checking bench for sort_engine (8x8 instance plus a 12-bit x 4 instance).
module tb_sort_engine;
  import sort_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sort_if #(.WIDTH(8),  .DEPTH(8)) bus1 ();
  sort_if #(.WIDTH(12), .DEPTH(4)) bus2 ();

  sort_engine #(.WIDTH(8),  .DEPTH(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  sort_engine #(.WIDTH(12), .DEPTH(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic [7:0] v [8]);
    for (int n = 0; n < 8; n++) begin
      bus1.init_mode = 1'b1;
      bus1.init_addr = 3'(n);
      bus1.init_data = v[n];
      tick();
    end
    bus1.init_mode = 1'b0;
  endtask

  // Starts a sort and counts busy cycles; at busy cycle 'poke' drives a
  // start pulse plus a write of 8'hFF to address 0, both of which must be ignored.
  task automatic run1(input logic d, input int poke, output int lat);
    bus1.desc = d;
    bus1.s    = 1'b1;
    tick();
    bus1.s = 1'b0;
    lat = 0;
    while (bus1.busy && lat < 200) begin
      lat++;
      if (lat == poke) begin
        bus1.s         = 1'b1;
        bus1.init_mode = 1'b1;
        bus1.init_addr = 3'd0;
        bus1.init_data = 8'hFF;
      end
      tick();
      bus1.s         = 1'b0;
      bus1.init_mode = 1'b0;
    end
  endtask

  task automatic read_check1(input string tag, input logic [7:0] exp [8]);
    for (int n = 0; n < 8; n++) begin
      bus1.rd_addr = 3'(n);
      #1;
      check($sformatf("%s[%0d]", tag, n), 32'(bus1.rd_data), 32'(exp[n]));
    end
  endtask

  logic [7:0]  data_a   [8] = '{8'h05, 8'h03, 8'h07, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04};
  logic [7:0]  sort_asc [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0]  sort_dsc [8] = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
  logic [7:0]  all_aa   [8] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
  logic [7:0]  zeros    [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [11:0] data_w   [4] = '{12'hFFF, 12'h000, 12'h800, 12'h7FF};
  logic [11:0] sort_w   [4] = '{12'h000, 12'h7FF, 12'h800, 12'hFFF};

  initial begin
    int lat;
    reset = 1'b1;
    bus1.s = 1'b0; bus1.desc = 1'b0; bus1.init_mode = 1'b0;
    bus1.init_addr = '0; bus1.init_data = '0; bus1.rd_addr = '0;
    bus2.s = 1'b0; bus2.desc = 1'b0; bus2.init_mode = 1'b0;
    bus2.init_addr = '0; bus2.init_data = '0; bus2.rd_addr = '0;
    tick();
    tick();
    check("reset_busy", 32'(bus1.busy), 32'd0);
    check("reset_done", 32'(bus1.done), 32'd0);
    read_check1("reset_mem", zeros);
    reset = 1'b0;
    tick();

    // Ascending sort of the reference pattern.
    load1(data_a);
    run1(ASCENDING, -1, lat);
    check("asc_latency", 32'(lat), 32'd42);
    check("asc_done", 32'(bus1.done), 32'd1);
    read_check1("asc", sort_asc);
`ifdef SORT_SWAP_COUNT_EN
    // Passes i=0..5 each bring a new minimum forward; pass 6 is already ordered.
    check("asc_swaps", 32'(bus1.swap_count), 32'd6);
`endif

    // Restart in the first DONE cycle, descending over the same value set.
    run1(DESCENDING, -1, lat);
    check("dsc_latency", 32'(lat), 32'd42);
    check("dsc_done", 32'(bus1.done), 32'd1);
    read_check1("dsc", sort_dsc);
`ifdef SORT_SWAP_COUNT_EN
    check("dsc_swaps", 32'(bus1.swap_count), 32'd4);
`endif

    // Equal values never swap.
    load1(all_aa);
    check("load_clears_done", 32'(bus1.done), 32'd0);
    run1(ASCENDING, -1, lat);
    check("eq_latency", 32'(lat), 32'd42);
    read_check1("eq", all_aa);
`ifdef SORT_SWAP_COUNT_EN
    check("eq_swaps", 32'(bus1.swap_count), 32'd0);
`endif

    // Reset during the 20th busy cycle.
    load1(data_a);
    bus1.s = 1'b1;
    tick();
    bus1.s = 1'b0;
    for (int n = 0; n < 19; n++) tick();
    check("pre_reset_busy", 32'(bus1.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus1.busy), 32'd0);
    check("abort_done", 32'(bus1.done), 32'd0);
    read_check1("abort_mem", zeros);
    tick();
    reset = 1'b0;
    tick();
    load1(data_a);
    run1(ASCENDING, -1, lat);
    check("post_reset_latency", 32'(lat), 32'd42);
    read_check1("post_reset", sort_asc);

    // Start pulse and write while busy are ignored; a later write clears done.
    load1(data_a);
    run1(ASCENDING, 10, lat);
    check("ignore_latency", 32'(lat), 32'd42);
    check("ignore_done", 32'(bus1.done), 32'd1);
    read_check1("ignore", sort_asc);
    bus1.init_mode = 1'b1;
    bus1.init_addr = 3'd0;
    bus1.init_data = 8'h01;
    tick();
    bus1.init_mode = 1'b0;
    check("write_clears_done", 32'(bus1.done), 32'd0);
    check("write_idle_busy", 32'(bus1.busy), 32'd0);

    // 12-bit x 4 instance: latency 4*3/2 + 2*3 = 12.
    for (int n = 0; n < 4; n++) begin
      bus2.init_mode = 1'b1;
      bus2.init_addr = 2'(n);
      bus2.init_data = data_w[n];
      tick();
    end
    bus2.init_mode = 1'b0;
    bus2.desc = ASCENDING;
    bus2.s    = 1'b1;
    tick();
    bus2.s = 1'b0;
    lat = 0;
    while (bus2.busy && lat < 200) begin
      lat++;
      tick();
    end
    check("w12_latency", 32'(lat), 32'd12);
    check("w12_done", 32'(bus2.done), 32'd1);
    for (int n = 0; n < 4; n++) begin
      bus2.rd_addr = 2'(n);
      #1;
      check($sformatf("w12[%0d]", n), 32'(bus2.rd_data), 32'(sort_w[n]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
